// File: rtl/axi_pkg.sv
// Shared types for the AXI burst memory slave: response codes, FSM states,
// default widths and the write-response priority rule.
package axi_pkg;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;
    localparam int AXI_LEN_W  = 8;
    localparam int MEM_AW     = 8;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'd0,
        RESP_SLVERR = 2'd2,
        RESP_DECERR = 2'd3
    } resp_t;

    typedef enum logic {
        R_IDLE,
        R_BURST
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_t;

    // A decode error outranks a wlast mismatch.
    function automatic resp_t wr_resp(input logic err, input logic mismatch);
        if (err)      return RESP_DECERR;
        if (mismatch) return RESP_SLVERR;
        return RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_burst_mem_slave_if.sv
// AXI4 read/write channel bundle between the DMA master and the burst
// memory slave.
interface axi_burst_mem_slave_if
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = AXI_ADDR_W,
    parameter int DATA_WIDTH = AXI_DATA_W,
    parameter int BURST_LEN  = AXI_LEN_W
) ();

    logic [ADDR_WIDTH-1:0] araddr;
    logic [BURST_LEN-1:0]  arlen;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    logic [ADDR_WIDTH-1:0] awaddr;
    logic [BURST_LEN-1:0]  awlen;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    modport master (
        output araddr, arlen, arvalid, rready,
        output awaddr, awlen, awvalid, wdata, wlast, wvalid, bready,
        input  arready, rdata, rresp, rlast, rvalid,
        input  awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arlen, arvalid, rready,
        input  awaddr, awlen, awvalid, wdata, wlast, wvalid, bready,
        output arready, rdata, rresp, rlast, rvalid,
        output awready, wready, bresp, bvalid
    );

endinterface

// File: rtl/axi_mem_array.sv
// Word-addressed register file: one write port, one synchronous read port.
// A same-index read and write in one cycle returns the old word.
module axi_mem_array
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = MEM_AW,
    parameter int DATA_WIDTH = AXI_DATA_W
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // NOTE: storage and the read register carry no reset; contents must survive
    // sys_rst_n, and the top masks rdata while no beat is valid.
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_burst_mem_slave.sv
// AXI4 INCR-burst memory slave: independent read and write FSMs sharing one
// register file, with DECERR for out-of-range starts and SLVERR on wlast mismatch.
module axi_burst_mem_slave
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH     = AXI_ADDR_W,
    parameter int DATA_WIDTH     = AXI_DATA_W,
    parameter int BURST_LEN      = AXI_LEN_W,
    parameter int MEM_ADDR_WIDTH = MEM_AW
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    axi_burst_mem_slave_if.slave s_axi
);

    typedef logic [MEM_ADDR_WIDTH-1:0] idx_t;
    typedef logic [BURST_LEN-1:0]      len_t;

    function automatic logic addr_err(input logic [ADDR_WIDTH-1:0] addr);
        return addr[ADDR_WIDTH-1:MEM_ADDR_WIDTH] != '0;
    endfunction

    rd_state_t rd_state_q;
    idx_t      rd_idx_q;
    len_t      rd_len_q;
    len_t      rd_cnt_q;
    logic      rd_err_q;
    logic      arready_q;
    logic      rvalid_q;
    logic      rlast_q;
    resp_t     rresp_q;

    wr_state_t wr_state_q;
    idx_t      wr_idx_q;
    len_t      wr_len_q;
    len_t      wr_cnt_q;
    logic      wr_err_q;
    logic      wr_mismatch_q;
    logic      awready_q;
    logic      wready_q;
    logic      bvalid_q;
    resp_t     bresp_q;

    logic                  ar_hs;
    logic                  r_hs;
    logic                  aw_hs;
    logic                  w_hs;
    logic                  wr_last_beat;
    logic                  wr_mismatch_d;
    logic                  mem_re;
    logic                  mem_we;
    idx_t                  mem_raddr;
    logic [DATA_WIDTH-1:0] mem_rdata;

    assign ar_hs = s_axi.arvalid && arready_q;
    assign r_hs  = rvalid_q && s_axi.rready;
    assign aw_hs = s_axi.awvalid && awready_q;
    assign w_hs  = s_axi.wvalid && wready_q;

    // The array is read one cycle ahead of each beat; a stalled beat simply
    // does not re-issue the read, so the registered word holds.
    assign mem_re    = ar_hs || (r_hs && !rlast_q);
    assign mem_raddr = (rd_state_q == R_IDLE) ? s_axi.araddr[MEM_ADDR_WIDTH-1:0]
                                              : rd_idx_q + idx_t'(1);

    assign wr_last_beat  = (wr_cnt_q == wr_len_q);
    assign wr_mismatch_d = wr_mismatch_q || (s_axi.wlast != wr_last_beat);
    assign mem_we        = sys_rst_n && w_hs && !wr_err_q;

    axi_mem_array #(
        .ADDR_WIDTH (MEM_ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mem (
        .clk_i   (sys_clk),
        .we_i    (mem_we),
        .waddr_i (wr_idx_q),
        .wdata_i (s_axi.wdata),
        .re_i    (mem_re),
        .raddr_i (mem_raddr),
        .rdata_o (mem_rdata)
    );

    // NOTE: all FSM state and registered outputs use non-blocking assignments
    // so every field updates from the same pre-edge values.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            rd_state_q <= R_IDLE;
            rd_idx_q   <= '0;
            rd_len_q   <= '0;
            rd_cnt_q   <= '0;
            rd_err_q   <= 1'b0;
            arready_q  <= 1'b1;
            rvalid_q   <= 1'b0;
            rlast_q    <= 1'b0;
            rresp_q    <= RESP_OKAY;
        end else begin
            case (rd_state_q)
                R_IDLE: begin
                    if (ar_hs) begin
                        rd_idx_q   <= s_axi.araddr[MEM_ADDR_WIDTH-1:0];
                        rd_len_q   <= s_axi.arlen;
                        rd_cnt_q   <= '0;
                        rd_err_q   <= addr_err(s_axi.araddr);
                        rresp_q    <= addr_err(s_axi.araddr) ? RESP_DECERR : RESP_OKAY;
                        rlast_q    <= (s_axi.arlen == '0);
                        rvalid_q   <= 1'b1;
                        arready_q  <= 1'b0;
                        rd_state_q <= R_BURST;
                    end
                end
                R_BURST: begin
                    if (r_hs) begin
                        if (rlast_q) begin
                            rvalid_q   <= 1'b0;
                            rlast_q    <= 1'b0;
                            rresp_q    <= RESP_OKAY;
                            arready_q  <= 1'b1;
                            rd_state_q <= R_IDLE;
                        end else begin
                            rd_cnt_q <= rd_cnt_q + len_t'(1);
                            rd_idx_q <= rd_idx_q + idx_t'(1);
                            rlast_q  <= ((rd_cnt_q + len_t'(1)) == rd_len_q);
                        end
                    end
                end
                default: rd_state_q <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            wr_state_q    <= W_IDLE;
            wr_idx_q      <= '0;
            wr_len_q      <= '0;
            wr_cnt_q      <= '0;
            wr_err_q      <= 1'b0;
            wr_mismatch_q <= 1'b0;
            awready_q     <= 1'b1;
            wready_q      <= 1'b0;
            bvalid_q      <= 1'b0;
            bresp_q       <= RESP_OKAY;
        end else begin
            case (wr_state_q)
                W_IDLE: begin
                    if (aw_hs) begin
                        wr_idx_q      <= s_axi.awaddr[MEM_ADDR_WIDTH-1:0];
                        wr_len_q      <= s_axi.awlen;
                        wr_cnt_q      <= '0;
                        wr_err_q      <= addr_err(s_axi.awaddr);
                        wr_mismatch_q <= 1'b0;
                        awready_q     <= 1'b0;
                        wready_q      <= 1'b1;
                        wr_state_q    <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_hs) begin
                        wr_mismatch_q <= wr_mismatch_d;
                        // The beat count, not wlast, decides where the burst ends.
                        if (wr_last_beat) begin
                            wready_q   <= 1'b0;
                            bvalid_q   <= 1'b1;
                            bresp_q    <= wr_resp(wr_err_q, wr_mismatch_d);
                            wr_state_q <= W_RESP;
                        end else begin
                            wr_cnt_q <= wr_cnt_q + len_t'(1);
                            wr_idx_q <= wr_idx_q + idx_t'(1);
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi.bready) begin
                        bvalid_q   <= 1'b0;
                        bresp_q    <= RESP_OKAY;
                        awready_q  <= 1'b1;
                        wr_state_q <= W_IDLE;
                    end
                end
                default: wr_state_q <= W_IDLE;
            endcase
        end
    end

    assign s_axi.arready = arready_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rlast   = rlast_q;
    assign s_axi.rresp   = rresp_q;
    assign s_axi.rdata   = (rvalid_q && !rd_err_q) ? mem_rdata : '0;
    assign s_axi.awready = awready_q;
    assign s_axi.wready  = wready_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = bresp_q;

endmodule

// File: tb/tb_axi_burst_mem_slave.sv
// Scoreboard bench for axi_burst_mem_slave: stimulus tasks queue expected R/B
// responses, a negedge monitor pops and compares them.
module tb_axi_burst_mem_slave;
    import axi_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 8;
    localparam int MW = 8;

    typedef struct {
        logic [DW-1:0] data;
        logic [1:0]    resp;
        logic          last;
    } r_exp_t;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;
    always #5 sys_clk = ~sys_clk;

    axi_burst_mem_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(LW)) bus ();

    axi_burst_mem_slave #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .BURST_LEN      (LW),
        .MEM_ADDR_WIDTH (MW)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .s_axi     (bus)
    );

    int          errors = 0;
    int          checks = 0;
    int          r_seen = 0;
    int          b_seen = 0;
    r_exp_t      r_q[$];
    logic [1:0]  b_q[$];
    logic [DW-1:0] model [256];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Monitor: compares every R/B handshake and checks stall stability.
    r_exp_t        mon_e;
    logic          stall_prev = 1'b0;
    logic [DW-1:0] stall_data;
    logic          stall_last;
    always @(negedge sys_clk) begin
        if (sys_rst_n && bus.rvalid) begin
            if (stall_prev) begin
                check("r_stall_data", bus.rdata, stall_data);
                check("r_stall_last", 32'(bus.rlast), 32'(stall_last));
            end
            if (bus.rready) begin
                if (r_q.size() == 0) begin
                    fail_now("r_unexpected_beat");
                end else begin
                    mon_e = r_q.pop_front();
                    check("r_data", bus.rdata, mon_e.data);
                    check("r_resp", 32'(bus.rresp), 32'(mon_e.resp));
                    check("r_last", 32'(bus.rlast), 32'(mon_e.last));
                end
                r_seen++;
                stall_prev = 1'b0;
            end else begin
                stall_prev = 1'b1;
                stall_data = bus.rdata;
                stall_last = bus.rlast;
            end
        end else begin
            stall_prev = 1'b0;
        end
        if (sys_rst_n && bus.bvalid && bus.bready) begin
            if (b_q.size() == 0) fail_now("b_unexpected_resp");
            else check("b_resp", 32'(bus.bresp), 32'(b_q.pop_front()));
            b_seen++;
        end
    end

    // sel: 0 = awready, 1 = wready, 2 = arready. Returns at posedge+1 after the handshake.
    task automatic wait_hs(input int sel, input string name);
        logic hs;
        int   to;
        to = 0;
        do begin
            @(negedge sys_clk);
            case (sel)
                0:       hs = bus.awready;
                1:       hs = bus.wready;
                default: hs = bus.arready;
            endcase
            @(posedge sys_clk);
            #1;
            to++;
        end while (!hs && to < 100);
        if (!hs) fail_now(name);
    endtask

    task automatic write_burst(input logic [AW-1:0] addr, input int len,
                               input logic [DW-1:0] base, input int wlast_beat,
                               input logic [1:0] exp_resp);
        int target;
        int to;
        target = b_seen + 1;
        b_q.push_back(exp_resp);
        if (exp_resp != RESP_DECERR)
            for (int i = 0; i <= len; i++) model[(addr + i) & 32'hff] = base + i;
        bus.awaddr  = addr;
        bus.awlen   = len[LW-1:0];
        bus.awvalid = 1'b1;
        wait_hs(0, "aw_handshake");
        bus.awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            bus.wdata  = base + i;
            bus.wlast  = (i == wlast_beat);
            bus.wvalid = 1'b1;
            wait_hs(1, "w_handshake");
        end
        bus.wvalid = 1'b0;
        bus.wlast  = 1'b0;
        to = 0;
        while (b_seen < target && to < 200) begin
            @(posedge sys_clk);
            #1;
            to++;
        end
        if (b_seen < target) fail_now("b_wait");
    endtask

    // mode 0: rready held high; mode 1: rready pattern 1,0,0 repeating.
    task automatic read_burst(input logic [AW-1:0] addr, input int len, input int mode);
        r_exp_t e;
        int     target;
        int     cyc;
        logic   err;
        target = r_seen + len + 1;
        err    = (addr >= 32'd256);
        for (int i = 0; i <= len; i++) begin
            e.data = err ? '0 : model[(addr + i) & 32'hff];
            e.resp = err ? RESP_DECERR : RESP_OKAY;
            e.last = (i == len);
            r_q.push_back(e);
        end
        bus.araddr  = addr;
        bus.arlen   = len[LW-1:0];
        bus.arvalid = 1'b1;
        wait_hs(2, "ar_handshake");
        bus.arvalid = 1'b0;
        cyc = 0;
        while (r_seen < target && cyc < 2000) begin
            if (mode == 1) bus.rready = (cyc % 3 == 0);
            @(posedge sys_clk);
            #1;
            cyc++;
        end
        bus.rready = 1'b1;
        if (r_seen < target) fail_now("r_wait");
    endtask

    initial begin
        int     rv_cnt;
        int     base;
        int     to;
        r_exp_t e;

        bus.araddr = '0; bus.arlen = '0; bus.arvalid = 1'b0; bus.rready = 1'b1;
        bus.awaddr = '0; bus.awlen = '0; bus.awvalid = 1'b0;
        bus.wdata  = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b1;

        repeat (3) @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
        @(negedge sys_clk);
        check("rst_arready", 32'(bus.arready), 32'd1);
        check("rst_awready", 32'(bus.awready), 32'd1);
        check("rst_rvalid",  32'(bus.rvalid),  32'd0);
        check("rst_rlast",   32'(bus.rlast),   32'd0);
        check("rst_rdata",   bus.rdata,        32'd0);
        check("rst_rresp",   32'(bus.rresp),   32'd0);
        check("rst_wready",  32'(bus.wready),  32'd0);
        check("rst_bvalid",  32'(bus.bvalid),  32'd0);
        check("rst_bresp",   32'(bus.bresp),   32'd0);
        @(posedge sys_clk);
        #1;

        // Fill the whole array so every later read has a known expectation.
        write_burst(32'd0, 255, 32'h1000, 255, RESP_OKAY);

        write_burst(32'd8, 19, 32'd100, 19, RESP_OKAY);
        read_burst(32'd15, 2, 0);

        // Single-beat read: rvalid for exactly one cycle, arready back next cycle.
        e.data = model[8]; e.resp = RESP_OKAY; e.last = 1'b1;
        r_q.push_back(e);
        base = r_seen;
        bus.araddr  = 32'd8;
        bus.arlen   = '0;
        bus.arvalid = 1'b1;
        wait_hs(2, "ar_len0");
        bus.arvalid = 1'b0;
        rv_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge sys_clk);
            if (bus.rvalid) rv_cnt++;
            if (i == 1) check("len0_arready_back", 32'(bus.arready), 32'd1);
        end
        check("len0_rvalid_cycles", rv_cnt, 32'd1);
        check("len0_beats", r_seen - base, 32'd1);
        @(posedge sys_clk);
        #1;

        read_burst(32'd8, 15, 1);

        fork
            write_burst(32'd2, 9, 32'd300, 9, RESP_OKAY);
            read_burst(32'd25, 19, 0);
        join

        write_burst(32'd250, 9, 32'd200, 9, RESP_OKAY);
        read_burst(32'd250, 9, 0);

        write_burst(32'h100, 3, 32'd900, 3, RESP_DECERR);
        read_burst(32'd0, 3, 0);
        read_burst(32'h100, 1, 0);

        write_burst(32'd40, 3, 32'd500, 1, RESP_SLVERR);
        read_burst(32'd40, 3, 0);

        // Reset while beat 5 of a 16-beat read is on the bus.
        base = r_seen;
        for (int i = 0; i < 16; i++) begin
            e.data = model[8 + i]; e.resp = RESP_OKAY; e.last = (i == 15);
            r_q.push_back(e);
        end
        bus.araddr  = 32'd8;
        bus.arlen   = 8'd15;
        bus.arvalid = 1'b1;
        wait_hs(2, "ar_reset_test");
        bus.arvalid = 1'b0;
        to = 0;
        while (r_seen < base + 4 && to < 200) begin
            @(posedge sys_clk);
            #1;
            to++;
        end
        if (r_seen < base + 4) fail_now("reset_test_wait");
        bus.rready = 1'b0;
        sys_rst_n  = 1'b0;
        @(negedge sys_clk);
        @(posedge sys_clk);
        #1;
        @(negedge sys_clk);
        check("midrst_rvalid",  32'(bus.rvalid),  32'd0);
        check("midrst_arready", 32'(bus.arready), 32'd1);
        check("midrst_pending", r_q.size(), 32'd12);
        r_q.delete();
        @(posedge sys_clk);
        #1;
        sys_rst_n  = 1'b1;
        bus.rready = 1'b1;
        @(posedge sys_clk);
        #1;
        read_burst(32'd15, 2, 0);

        repeat (5) @(posedge sys_clk);
        check("r_queue_drained", r_q.size(), 32'd0);
        check("b_queue_drained", b_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/axi_burst_mem_slave.md
Name: axi_burst_mem_slave

Overview:
Memory-side AXI4 responder that terminates the DMA master's page-fault reads and write-back bursts in the sys_clk domain. It accepts INCR bursts on independent read and write channels and serves them from an internal word-addressed array. Read and write paths run concurrently. It is the slave end of the bus that the DMA master drives.

Parameters:
ADDR_WIDTH, 32, AXI address width (word address, one unit = one DATA_WIDTH word)
DATA_WIDTH, 32, read/write data width
BURST_LEN, 8, width of arlen/awlen (beats = len+1, max 256)
MEM_ADDR_WIDTH, 8, log2 of array depth (256 words)

Ports:
sys_clk  in  1  clock
sys_rst_n  in  1  synchronous active-low reset
araddr  in  ADDR_WIDTH  read burst start address
arlen  in  BURST_LEN  read beats minus one
arvalid / arready  in / out  1  AR handshake
rdata  out  DATA_WIDTH  read data
rresp  out  2  OKAY=0, SLVERR=2, DECERR=3
rlast  out  1  final read beat
rvalid / rready  out / in  1  R handshake
awaddr  in  ADDR_WIDTH  write burst start address
awlen  in  BURST_LEN  write beats minus one
awvalid / awready  in / out  1  AW handshake
wdata  in  DATA_WIDTH  write data
wlast  in  1  master's final-beat flag
wvalid / wready  in / out  1  W handshake
bresp  out  2  write response
bvalid / bready  out / in  1  B handshake

Behaviour:
- One clock (sys_clk); reset is synchronous and active-low (sys_rst_n). Reset forces both FSMs to idle. After reset: arready=1, awready=1, rvalid=0, rlast=0, rdata=0, rresp=0, wready=0, bvalid=0, bresp=0. Array contents are not cleared and survive reset.
- Reset mid-burst: the in-flight burst is abandoned with no response and no further array writes.
- Read FSM states are R_IDLE and R_BURST.
  - R_IDLE: arready=1. On arvalid&&arready, latch addr, len, and err = (araddr >= 2**MEM_ADDR_WIDTH). Beat counter is cleared. Move to R_BURST.
  - R_BURST: arready=0. rvalid rises the cycle after the AR handshake (1-cycle latency). rdata = mem[idx], or 0 if err. rresp = DECERR if err, else OKAY. rlast = (cnt==len).
  - While rvalid&&!rready, rdata, rresp and rlast hold stable.
  - On rvalid&&rready: if not last, increment cnt and idx, and present the next beat in the next cycle (full throughput when rready is held high). If last, go to R_IDLE, drop rvalid, and raise arready in the same edge.
- Write FSM states are W_IDLE, W_DATA and W_RESP.
  - W_IDLE: awready=1. On AW handshake, latch addr, len and err, clear cnt and the mismatch flag, and move to W_DATA.
  - W_DATA: wready=1. Each W handshake writes wdata to mem[idx] unless err. Mismatch is set if wlast != (cnt==len). The burst ends on cnt==len regardless of wlast, then moves to W_RESP.
  - W_RESP: bvalid=1. bresp = DECERR if err, else SLVERR if mismatch, else OKAY. Hold until bready, then go to W_IDLE.
- Index arithmetic: idx = start[MEM_ADDR_WIDTH-1:0] + cnt, modulo 2**MEM_ADDR_WIDTH. Bursts wrap silently at the top of the array. The err range check applies to the start address only.
- len=0 is a single beat: rlast is asserted on the first beat, and a single W beat moves the write FSM to W_RESP.
- Simultaneous read and write of the same index in one cycle: the read returns the old value (read-before-write).
- AR and AW may handshake in the same cycle. The two paths never stall each other.
- A write burst followed by a read of the same words returns the new data once bvalid has been observed.

Decomposition:
- Shared package axi_pkg holds:
  - response codes RESP_OKAY/RESP_SLVERR/RESP_DECERR
  - rd_state_t {R_IDLE,R_BURST} and wr_state_t {W_IDLE,W_DATA,W_RESP}
  - the width localparams.
- One sub-module, axi_mem_array: a 2**MEM_ADDR_WIDTH x DATA_WIDTH register file with one write port (we, waddr, wdata) and one synchronous read port (re, raddr, rdata) with read-before-write. The read-side stall hold is done by not re-issuing re.

Test Plan:
- Write 20 beats at addr 8 (data 100+i, wlast on beat 19), then read 3 beats at addr 15 -> rdata 107,108,109; rlast on beat 3 only; bresp=OKAY; rresp=OKAY.
- Read len=0 at addr 8 -> one beat, rdata=100, rlast=1, rvalid high exactly one cycle with rready=1; arready back high the next cycle.
- Read 16 beats at addr 8 with rready toggling 1,0,0,1… -> every beat delivered in order (100..115), with rdata/rlast stable during stall cycles.
- Concurrent write of 10 beats at addr 2 and read of 20 beats at addr 25 (AR/AW in the same cycle) -> both complete, read data unaffected, bresp=OKAY, no lost beats.
- Write 10 beats at addr 250 -> words 250..255 then 0..3 written (wrap); read-back matches. Write at addr 0x100 -> bresp=DECERR and array unchanged. Read at 0x100 -> rdata=0, rresp=DECERR.
- wlast asserted on beat 2 of a 4-beat write -> 4 beats accepted, bresp=SLVERR. Separately, assert sys_rst_n=0 during read beat 5 -> rvalid=0 and arready=1 after the reset edge; a new read proceeds normally.
